// File: rtl/rvb_bextdep_iter_if.sv
// Execute-slot bus for the iterative bext/bdep unit: one request channel and one result channel.
// Both channels use valid/ready: a beat transfers on a rising clock edge where valid and ready are both high.
// The producer holds valid and its payload steady until that edge; ready never depends on the same channel's valid.
interface rvb_bextdep_iter_if #(
   parameter int XLEN = 32
);
   logic            din_valid;
   logic            din_ready;
   logic [XLEN-1:0] din_rs1;
   logic [XLEN-1:0] din_rs2;
   logic            din_bdep;
   logic            din_word;
   logic            dout_valid;
   logic            dout_ready;
   logic [XLEN-1:0] dout_rd;

   modport master (
      output din_valid, din_rs1, din_rs2, din_bdep, din_word, dout_ready,
      input  din_ready, dout_valid, dout_rd
   );

   modport slave (
      input  din_valid, din_rs1, din_rs2, din_bdep, din_word, dout_ready,
      output din_ready, dout_valid, dout_rd
   );
endinterface

// File: rtl/rvb_bextdep_iter.sv
// Iterative bext/bdep: walks CHUNK mask bits per BUSY cycle, with optional early exit
// once no set mask bits remain above the current chunk, and 32-bit word ops on XLEN=64.
module rvb_bextdep_iter #(
   parameter int XLEN       = 32,
   parameter int CHUNK      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                 clock,
   input  logic                 resetn,
   rvb_bextdep_iter_if.slave    io,
   output logic [1:0]           dbg_state
);
   localparam int AW = $clog2(XLEN);
   localparam int KW = AW + 1;
   localparam int CL = $clog2(CHUNK);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [XLEN-1:0] LO32      = XLEN'(64'h0000_0000_FFFF_FFFF);
   localparam logic [KW-1:0]   LAST_FULL = KW'(XLEN / CHUNK - 1);
   localparam logic [KW-1:0]   LAST_WORD = KW'(32 / CHUNK - 1);
   localparam logic [KW-1:0]   CHUNK_K   = KW'(CHUNK);
   localparam logic [KW-1:0]   ONE_K     = KW'(1);

   logic [1:0]      state;
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] msk;
   logic [XLEN-1:0] res;
   logic [KW-1:0]   k;
   logic [KW-1:0]   p;
   logic            op_bdep;
   logic            op_word;

   logic            accept;
   logic            word_in;
   logic [XLEN-1:0] in_mask;
   logic [XLEN-1:0] res_n;
   logic [KW-1:0]   k_n;
   logic [KW-1:0]   base;
   logic [KW-1:0]   idx;
   logic            hi_zero;
   logic            last;
   logic            finish;

   assign io.din_ready = (state == S_IDLE) | ((state == S_DONE) & io.dout_ready);
   assign accept       = io.din_valid & io.din_ready;

   // Word qualifier only exists on a 64-bit datapath; the low-32 mask also keeps src bits above W-1 out of reach.
   assign word_in = (XLEN == 64) ? io.din_word : 1'b0;
   assign in_mask = word_in ? LO32 : '1;

   always_comb begin
      res_n = res;
      k_n   = k;
      base  = p << CL;
      idx   = base;
      for (int i = 0; i < CHUNK; i++) begin
         idx = base + KW'(i);
         if (msk[idx[AW-1:0]]) begin
            if (op_bdep) res_n[idx[AW-1:0]] = src[k_n[AW-1:0]];
            else         res_n[k_n[AW-1:0]] = src[idx[AW-1:0]];
            k_n = k_n + ONE_K;
         end
      end
      hi_zero = (msk >> (base + CHUNK_K)) == '0;
      last    = p == (op_word ? LAST_WORD : LAST_FULL);
      finish  = last | (EARLY_EXIT & hi_zero);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         src     <= '0;
         msk     <= '0;
         res     <= '0;
         k       <= '0;
         p       <= '0;
         op_bdep <= 1'b0;
         op_word <= 1'b0;
      end else if (accept) begin
         // Covers both a fresh request from IDLE and retire-plus-accept from DONE.
         state   <= S_BUSY;
         src     <= io.din_rs1 & in_mask;
         msk     <= io.din_rs2 & in_mask;
         res     <= '0;
         k       <= '0;
         p       <= '0;
         op_bdep <= io.din_bdep;
         op_word <= word_in;
      end else begin
         case (state)
            S_BUSY: begin
               res <= res_n;
               k   <= k_n;
               p   <= p + ONE_K;
               if (finish) state <= S_DONE;
            end
            S_DONE: begin
               if (io.dout_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Upper result bits are zero for word ops, so OR-ing in the sign fill is a plain sign extension.
   assign io.dout_valid = state == S_DONE;
   assign io.dout_rd    = op_word ? (res | (res[31] ? ~LO32 : '0)) : res;
   assign dbg_state     = state;
endmodule

// File: tb/tb_rvb_bextdep_iter.sv
// Bench for rvb_bextdep_iter: five parameterisations side by side, directed vectors with
// hand-computed results and latencies, stall/back-to-back/reset cases, then model-checked random ops.
module tb_rvb_bextdep_iter;
   localparam int NDUT = 5;

   logic        clock = 1'b0;
   logic        resetn;
   logic        dv  [NDUT];
   logic        bdp [NDUT];
   logic        wrd [NDUT];
   logic        dor [NDUT];
   logic [63:0] rs1 [NDUT];
   logic [63:0] rs2 [NDUT];
   wire         drdy   [NDUT];
   wire         ovalid [NDUT];
   wire  [63:0] ord    [NDUT];
   wire  [1:0]  dst    [NDUT];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   // 0: X32/C8/EE  1: X32/C8/fixed  2: X64/C4/EE  3: X64/C1/fixed  4: X32/C32/EE
   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int XL = (g == 2 || g == 3) ? 64 : 32;
      localparam int CH = (g == 2) ? 4 : (g == 3) ? 1 : (g == 4) ? 32 : 8;
      localparam bit EE = (g == 1 || g == 3) ? 1'b0 : 1'b1;

      rvb_bextdep_iter_if #(.XLEN(XL)) io ();

      assign io.din_valid  = dv[g];
      assign io.din_bdep   = bdp[g];
      assign io.din_word   = wrd[g];
      assign io.dout_ready = dor[g];
      assign io.din_rs1    = rs1[g][XL-1:0];
      assign io.din_rs2    = rs2[g][XL-1:0];
      assign drdy[g]       = io.din_ready;
      assign ovalid[g]     = io.dout_valid;
      assign ord[g]        = 64'(io.dout_rd);

      rvb_bextdep_iter #(.XLEN(XL), .CHUNK(CH), .EARLY_EXIT(EE)) u_dut (
         .clock     (clock),
         .resetn    (resetn),
         .io        (io),
         .dbg_state (dst[g])
      );
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int xl_of(input int d);
      return (d == 2 || d == 3) ? 64 : 32;
   endfunction

   // Reference: straight bit loop over the whole operand width.
   function automatic logic [63:0] model(input int xl, input bit op_bdep, input bit op_word,
                                         input logic [63:0] a, input logic [63:0] m);
      int          w;
      int          k;
      logic [63:0] r;
      w = (xl == 64 && op_word) ? 32 : xl;
      k = 0;
      r = '0;
      for (int i = 0; i < w; i++) begin
         if (m[i]) begin
            if (op_bdep) r[i] = a[k];
            else         r[k] = a[i];
            k++;
         end
      end
      if (xl == 64 && op_word) r[63:32] = {32{r[31]}};
      return r;
   endfunction

   task automatic send(input int d, input bit b, input bit w, input logic [63:0] a, input logic [63:0] m);
      int budget;
      budget = 0;
      @(negedge clock);
      dv[d]  = 1'b1;
      bdp[d] = b;
      wrd[d] = w;
      rs1[d] = a;
      rs2[d] = m;
      while (!drdy[d] && budget < 50) begin
         @(negedge clock);
         budget++;
      end
      @(posedge clock);
      #1;
      dv[d]  = 1'b0;
      rs1[d] = {$urandom(), $urandom()};
      rs2[d] = {$urandom(), $urandom()};
   endtask

   // Counts rising edges from the accept edge until dout_valid is seen high.
   task automatic wait_valid(input int d, output int lat);
      lat = 0;
      do begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end while (!ovalid[d] && lat < 200);
   endtask

   task automatic retire(input int d);
      dor[d] = 1'b1;
      @(posedge clock);
      #1;
      dor[d] = 1'b0;
   endtask

   task automatic run_op(input string tag, input int d, input bit b, input bit w,
                         input logic [63:0] a, input logic [63:0] m, input int hold,
                         output logic [63:0] res, output int lat);
      send(d, b, w, a, m);
      wait_valid(d, lat);
      check({tag, "_vld"}, 64'(ovalid[d]), 64'd1);
      repeat (hold) @(negedge clock);
      res = ord[d];
      retire(d);
   endtask

   task automatic dir(input string tag, input int d, input bit b, input bit w,
                      input logic [63:0] a, input logic [63:0] m,
                      input logic [63:0] exp, input int exp_lat);
      logic [63:0] r;
      int          l;
      run_op(tag, d, b, w, a, m, 0, r, l);
      check(tag, r, exp);
      check({tag, "_lat"}, 64'(l), 64'(exp_lat));
   endtask

   initial begin
      logic [63:0] r;
      logic [63:0] a;
      logic [63:0] m;
      int          l;
      int          seen;
      bit          b;
      bit          w;

      resetn = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         dv[i]  = 1'b0;
         bdp[i] = 1'b0;
         wrd[i] = 1'b0;
         dor[i] = 1'b0;
         rs1[i] = '0;
         rs2[i] = '0;
      end
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("rst%0d_vld", i), 64'(ovalid[i]), 64'd0);
         check($sformatf("rst%0d_rdy", i), 64'(drdy[i]), 64'd1);
         check($sformatf("rst%0d_rd", i), ord[i], 64'd0);
         check($sformatf("rst%0d_st", i), 64'(dst[i]), 64'd0);
      end

      dir("d0_bext",     0, 1'b0, 1'b0, 64'h1234_5678, 64'hFF00_FF00, 64'h1256, 4);
      dir("d0_bdep",     0, 1'b1, 1'b0, 64'hAB, 64'h0F0F_0000, 64'h0A0B_0000, 4);
      dir("d0_early",    0, 1'b0, 1'b0, 64'h1234_5678, 64'hFF, 64'h78, 1);
      dir("d0_zero",     0, 1'b1, 1'b0, 64'hFFFF_FFFF, 64'h0, 64'h0, 1);
      dir("d0_word_ign", 0, 1'b0, 1'b1, 64'h1234_5678, 64'hFF00_FF00, 64'h1256, 4);
      dir("d1_bext",     1, 1'b0, 1'b0, 64'h1234_5678, 64'hFF00_FF00, 64'h1256, 4);
      dir("d1_fixed",    1, 1'b0, 1'b0, 64'h1234_5678, 64'hFF, 64'h78, 4);
      dir("d1_zero",     1, 1'b1, 1'b0, 64'hFFFF_FFFF, 64'h0, 64'h0, 4);
      dir("d2_wbdep",    2, 1'b1, 1'b1, 64'hFF, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 8);
      dir("d2_wbext0",   2, 1'b0, 1'b1, 64'hFF, 64'h0, 64'h0, 1);
      dir("d2_wbext",    2, 1'b0, 1'b1, 64'hDEAD_0000_0000_F00F, 64'hFFFF_0000_0000_FFFF, 64'hF00F, 4);
      dir("d2_bext64",   2, 1'b0, 1'b0, 64'hF0F0_0000_0000_0001, 64'hFFFF_0000_0000_0001, 64'h1_E1E1, 16);
      dir("d3_wbext",    3, 1'b0, 1'b1, 64'h8000_0000, 64'h8000_0000, 64'h1, 32);
      dir("d3_wbdep",    3, 1'b1, 1'b1, 64'hFF, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 32);
      dir("d4_bdep",     4, 1'b1, 1'b0, 64'hAB, 64'h0F0F_0000, 64'h0A0B_0000, 1);

      // Result held under back-pressure, then retired on the same edge as the next accept.
      send(0, 1'b0, 1'b0, 64'h1234_5678, 64'hFF00_FF00);
      dv[0]  = 1'b1;
      bdp[0] = 1'b1;
      rs1[0] = 64'hAB;
      rs2[0] = 64'h0F0F_0000;
      wait_valid(0, l);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d_vld", c), 64'(ovalid[0]), 64'd1);
         check($sformatf("stall%0d_rd", c), ord[0], 64'h1256);
         check($sformatf("stall%0d_rdy", c), 64'(drdy[0]), 64'd0);
         @(negedge clock);
      end
      retire(0);
      dv[0] = 1'b0;
      @(negedge clock);
      check("b2b_state", 64'(dst[0]), 64'd1);
      check("b2b_vld_low", 64'(ovalid[0]), 64'd0);
      wait_valid(0, l);
      check("b2b_rd", ord[0], 64'h0A0B_0000);
      retire(0);
      @(negedge clock);
      check("b2b_idle", 64'(dst[0]), 64'd0);

      // Reset while BUSY: the op is lost and no result appears.
      send(1, 1'b0, 1'b0, 64'h1234_5678, 64'hFF00_FF00);
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clock);
         if (ovalid[1]) seen++;
      end
      check("rst_busy_vld", 64'(seen), 64'd0);
      check("rst_busy_st", 64'(dst[1]), 64'd0);

      // Reset while DONE: pending result is dropped.
      send(0, 1'b0, 1'b0, 64'h1234_5678, 64'hFF);
      wait_valid(0, l);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clock);
         if (ovalid[0]) seen++;
      end
      check("rst_done_vld", 64'(seen), 64'd0);
      check("rst_done_rd", ord[0], 64'd0);

      for (int d = 0; d < NDUT; d++) begin
         for (int n = 0; n < 40; n++) begin
            b = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
               0:       m = {$urandom(), $urandom()};
               1:       m = {$urandom() & $urandom(), $urandom() & $urandom()};
               2:       m = {32'h0, $urandom() & 32'h0000_FFFF};
               default: m = '1;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clock);
            run_op($sformatf("rnd%0d_%0d", d, n), d, b, w, a, m, $urandom_range(0, 3), r, l);
            check($sformatf("rnd%0d_%0d", d, n), r, model(xl_of(d), b, w, a, m));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
